// File: rtl/merger_output_buffer_if.sv
// rtl/merger_output_buffer_if.sv - merger output buffer network/consumer bus
interface merger_output_buffer_if #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Upstream bitonic network side
  logic                    i_stall;
  logic [4*DATA_WIDTH-1:0] i_elems;
  logic                    i_switch_output;
  logic                    o_stall_req;

  // Downstream merge level side
  logic                    o_valid;
  logic                    i_ready;
  logic [4*DATA_WIDTH-1:0] o_data;
  logic                    o_last;

  // Status
  logic [CNT_W-1:0]        o_count;
  logic                    o_overflow;

  // Environment that drives the network outputs and consumes the head
  modport master (
    output i_stall, i_elems, i_switch_output, i_ready,
    input  o_stall_req, o_valid, o_data, o_last, o_count, o_overflow
  );

  // The buffer itself
  modport slave (
    input  i_stall, i_elems, i_switch_output, i_ready,
    output o_stall_req, o_valid, o_data, o_last, o_count, o_overflow
  );
endinterface

// File: rtl/merger_output_buffer.sv
// rtl/merger_output_buffer.sv - FWFT tuple FIFO with early upstream stall request
module merger_output_buffer #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 8,
  parameter int LATENCY    = 3
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  merger_output_buffer_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TW     = 4 * DATA_WIDTH;
  // Stall once occupancy leaves room only for the in-flight tuples plus one
  localparam logic [CNT_W-1:0] STALL_THR = CNT_W'(DEPTH - LATENCY - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

  logic [TW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] last_q;

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             stall_req_q, overflow_q;

  logic wr_req, rd, full, wr;

  assign full   = (count_q == FULL_CNT);
  assign rd     = (count_q != '0) & bus.i_ready;
  assign wr_req = ~bus.i_stall;
  // A write into a full FIFO is still accepted when the head leaves this cycle
  assign wr     = wr_req & (~full | rd);

  // Next occupancy from the accepted write/read pair
  always_comb begin
    count_d = count_q;
    case ({wr, rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers, occupancy, registered stall request, sticky overflow
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      stall_req_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      stall_req_q <= (count_d > STALL_THR);
      if (wr_req && full && !rd) overflow_q <= 1'b1;
    end
  end

  // Tuple storage; contents are deliberately left unreset
  always_ff @(posedge i_clk) begin
    if (i_rst_n && wr) begin
      mem_q[wr_ptr_q]  <= bus.i_elems;
      last_q[wr_ptr_q] <= bus.i_switch_output;
    end
  end

  assign bus.o_valid     = (count_q != '0);
  assign bus.o_data      = bus.o_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.o_last      = bus.o_valid & last_q[rd_ptr_q];
  assign bus.o_count     = count_q;
  assign bus.o_stall_req = stall_req_q;
  assign bus.o_overflow  = overflow_q;
endmodule
